acc_seq_ctrl: RTL and testbench

ACC_SEQ_CTRL -- requirements
Module: acc_seq_ctrl

---
 rtl/acc_seq_if.sv | 35 +++
 rtl/acc_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_acc_seq_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/acc_seq_if.sv
// acc_seq_if -- command, ALU and status bundle for acc_seq_ctrl.
//   slave  : the controller side (acc_seq_ctrl)
//   master : the side that issues commands and supplies the combinational ALU
// Signals:
//   cmd_valid/cmd_ready/cmd_op[2:0]/cmd_data[3:0]  command handshake
//   alu_a/alu_b/alu_ctrl[3:0] -> ALU ; alu_result[3:0]/alu_ovr/alu_zero <- ALU
//   acc[3:0], ovr_flag, zero_flag                   architectural state
//   busy, done                                      progress / completion pulse
interface acc_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_ctrl;
  logic [3:0] alu_result;
  logic       alu_ovr;
  logic       alu_zero;
  logic [3:0] acc;
  logic       ovr_flag;
  logic       zero_flag;
  logic       busy;
  logic       done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_result, alu_ovr, alu_zero,
    output cmd_ready, alu_a, alu_b, alu_ctrl, acc, ovr_flag, zero_flag, busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_result, alu_ovr, alu_zero,
    input  cmd_ready, alu_a, alu_b, alu_ctrl, acc, ovr_flag, zero_flag, busy, done
  );
endinterface

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl -- 4-bit accumulator sequencer driving an external
// combinational ALU. Single ops take one EXEC cycle; MUL is done by
// repeated ALU ADDs (operand+1 cycles including the write-back cycle).
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : acc_seq_if.slave (command handshake, ALU drive/return, status)
module acc_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  acc_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] opnd_q, opnd_d;
  logic [3:0] acc_q, acc_d;
  logic       ovr_q, ovr_d;
  logic       zero_q, zero_d;
  logic       done_q, done_d;
  logic [3:0] prod_q, prod_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sticky_q, sticky_d;

  logic [3:0] alu_a, alu_b, alu_ctrl;

  // alu_zero is reserved; zero_flag is derived locally from the written value
  logic unused_alu_zero;
  assign unused_alu_zero = bus.alu_zero;

  function automatic logic [3:0] op2ctrl(input logic [2:0] op);
    case (op)
      OP_AND:  op2ctrl = CTRL_AND;
      OP_OR:   op2ctrl = CTRL_OR;
      OP_ADD:  op2ctrl = CTRL_ADD;
      OP_SUB:  op2ctrl = CTRL_SUB;
      OP_SLT:  op2ctrl = CTRL_SLT;
      OP_NOR:  op2ctrl = CTRL_NOR;
      default: op2ctrl = 4'b0000;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    ovr_d    = ovr_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    alu_a    = 4'd0;
    alu_b    = 4'd0;
    alu_ctrl = 4'b0000;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          opnd_d = bus.cmd_data;
          if (bus.cmd_op == OP_MUL) begin
            state_d  = MUL;
            prod_d   = 4'd0;
            cnt_d    = bus.cmd_data;
            sticky_d = 1'b0;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_q == OP_LOAD) begin
          acc_d  = opnd_q;
          ovr_d  = 1'b0;
          zero_d = (opnd_q == 4'd0);
        end else begin
          alu_a    = acc_q;
          alu_b    = opnd_q;
          alu_ctrl = op2ctrl(op_q);
          acc_d    = bus.alu_result;
          ovr_d    = bus.alu_ovr;
          zero_d   = (bus.alu_result == 4'd0);
        end
      end

      MUL: begin
        if (cnt_q != 4'd0) begin
          // one partial sum per cycle: prod += acc, carry folded into sticky
          alu_a    = prod_q;
          alu_b    = acc_q;
          alu_ctrl = CTRL_ADD;
          prod_d   = bus.alu_result;
          sticky_d = sticky_q | bus.alu_ovr;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          acc_d   = prod_q;
          ovr_d   = sticky_q;
          zero_d  = (prod_q == 4'd0);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      opnd_q   <= 4'd0;
      acc_q    <= 4'd0;
      ovr_q    <= 1'b0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      prod_q   <= 4'd0;
      cnt_q    <= 4'd0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      ovr_q    <= ovr_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.acc       = acc_q;
  assign bus.ovr_flag  = ovr_q;
  assign bus.zero_flag = zero_q;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_ctrl  = alu_ctrl;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb_acc_seq_ctrl -- self-checking bench for acc_seq_ctrl. Provides the
// combinational ALU and checks results against an arithmetic reference.
module tb_acc_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_seq_if bus();

  acc_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // ALU: ovr is carry-out for ADD, borrow for SUB, 0 otherwise
  logic [3:0] alu_r;
  logic       alu_o;
  always_comb begin
    logic [4:0] s;
    alu_r = 4'd0;
    alu_o = 1'b0;
    s     = 5'd0;
    case (bus.alu_ctrl)
      4'b0000: alu_r = bus.alu_a & bus.alu_b;
      4'b0001: alu_r = bus.alu_a | bus.alu_b;
      4'b0010: begin s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}; alu_r = s[3:0]; alu_o = s[4]; end
      4'b0110: begin alu_r = bus.alu_a - bus.alu_b; alu_o = (bus.alu_a < bus.alu_b); end
      4'b0111: alu_r = {3'b000, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      4'b1100: alu_r = ~(bus.alu_a | bus.alu_b);
      default: alu_r = 4'd0;
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_ovr    = alu_o;
  assign bus.alu_zero   = (alu_r == 4'd0);

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] m_acc;
  logic       m_ovr;
  logic       m_zero;

  // reference: whole-command result from plain arithmetic
  function automatic void ref_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] d,
                                 output logic [3:0] r, output logic o);
    int s;
    o = 1'b0;
    case (op)
      3'd0: r = d;
      3'd1: r = a & d;
      3'd2: r = a | d;
      3'd3: begin s = int'(a) + int'(d); r = s[3:0]; o = (s > 15); end
      3'd4: begin r = a - d; o = (a < d); end
      3'd5: r = (int'($signed(a)) < int'($signed(d))) ? 4'd1 : 4'd0;
      3'd6: r = ~(a | d);
      default: begin s = int'(a) * int'(d); r = s[3:0]; o = (s > 15); end
    endcase
  endfunction

  function automatic int ref_busy(input logic [2:0] op, input logic [3:0] d);
    return (op == 3'd7) ? int'(d) + 1 : 1;
  endfunction

  function automatic void model_apply(input logic [2:0] op, input logic [3:0] d);
    logic [3:0] r;
    logic       o;
    ref_op(op, m_acc, d, r, o);
    m_acc  = r;
    m_ovr  = o;
    m_zero = (r == 4'd0);
  endfunction

  // Issue one command from IDLE (called #1 after a rising edge). Returns busy
  // cycle count, done in the first IDLE cycle and done one cycle later.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] d,
                         output int bcyc, output logic rdy, output logic d_now, output logic d_next);
    rdy = bus.cmd_ready;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(posedge clk); #1;
    // scramble inputs after accept; running command must not notice
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_data  = 4'($urandom);
    bcyc = 0;
    while (bus.busy && bcyc < 40) begin
      bcyc++;
      @(posedge clk); #1;
    end
    d_now = bus.done;
    @(posedge clk); #1;
    d_next = bus.done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'd0;
    bus.cmd_data = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.acc !== 4'd0)     begin n_err++; $display("FAIL reset_acc got %0d want 0", bus.acc); end
    n_cmp++; if (bus.zero_flag !== 1'b1) begin n_err++; $display("FAIL reset_zero got %b want 1", bus.zero_flag); end
    n_cmp++; if (bus.ovr_flag !== 1'b0)  begin n_err++; $display("FAIL reset_ovr got %b want 0", bus.ovr_flag); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0)      begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b want 1", bus.cmd_ready); end
    m_acc = 4'd0; m_ovr = 1'b0; m_zero = 1'b1;
  endtask

  // LOAD x then op y, expected values written out by hand
  task automatic test_directed();
    logic [2:0]  t_op [8] = '{3'd3, 3'd4, 3'd5, 3'd1, 3'd6, 3'd7, 3'd7, 3'd7};
    logic [3:0]  t_ld [8] = '{4'd9, 4'd3, 4'd3, 4'd5, 4'd5, 4'd3, 4'd6, 4'd7};
    logic [3:0]  t_d  [8] = '{4'd9, 4'd5, 4'd5, 4'd10, 4'd10, 4'd5, 4'd3, 4'd0};
    logic [3:0]  t_acc[8] = '{4'd2, 4'd14, 4'd1, 4'd0, 4'd0, 4'd15, 4'd2, 4'd0};
    logic        t_ovr[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        t_zf [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int          t_bsy[8] = '{1, 1, 1, 1, 1, 6, 4, 1};
    int bc; logic rdy, dn, dx;
    for (int i = 0; i < 8; i++) begin
      run_cmd(3'd0, t_ld[i], bc, rdy, dn, dx);
      n_cmp++; if (bus.acc !== t_ld[i]) begin n_err++; $display("FAIL dir%0d_load acc got %0d want %0d", i, bus.acc, t_ld[i]); end
      run_cmd(t_op[i], t_d[i], bc, rdy, dn, dx);
      n_cmp++; if (bus.acc !== t_acc[i]) begin n_err++; $display("FAIL dir%0d_acc got %0d want %0d", i, bus.acc, t_acc[i]); end
      n_cmp++; if (bus.ovr_flag !== t_ovr[i]) begin n_err++; $display("FAIL dir%0d_ovr got %b want %b", i, bus.ovr_flag, t_ovr[i]); end
      n_cmp++; if (bus.zero_flag !== t_zf[i]) begin n_err++; $display("FAIL dir%0d_zero got %b want %b", i, bus.zero_flag, t_zf[i]); end
      n_cmp++; if (bc !== t_bsy[i]) begin n_err++; $display("FAIL dir%0d_busy got %0d want %0d", i, bc, t_bsy[i]); end
      n_cmp++; if ({rdy, dn, dx} !== 3'b110) begin n_err++; $display("FAIL dir%0d_done rdy/done/next got %b want 110", i, {rdy, dn, dx}); end
      m_acc = t_acc[i]; m_ovr = t_ovr[i]; m_zero = t_zf[i];
    end
  endtask

  task automatic test_random();
    int bc; logic rdy, dn, dx;
    logic [2:0] op; logic [3:0] d;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom);
      d  = 4'($urandom);
      run_cmd(op, d, bc, rdy, dn, dx);
      model_apply(op, d);
      n_cmp++; if ({bus.acc, bus.ovr_flag, bus.zero_flag} !== {m_acc, m_ovr, m_zero}) begin
        n_err++; $display("FAIL rnd%0d op=%0d d=%0d acc/ovr/zero got %0d/%b/%b want %0d/%b/%b",
                          i, op, d, bus.acc, bus.ovr_flag, bus.zero_flag, m_acc, m_ovr, m_zero);
      end
      n_cmp++; if (bc !== ref_busy(op, d)) begin n_err++; $display("FAIL rnd%0d_busy got %0d want %0d", i, bc, ref_busy(op, d)); end
      n_cmp++; if ({dn, dx} !== 2'b10) begin n_err++; $display("FAIL rnd%0d_done got %b want 10", i, {dn, dx}); end
    end
  endtask

  task automatic test_mul_reset();
    int bc; logic rdy, dn, dx;
    run_cmd(3'd0, 4'd4, bc, rdy, dn, dx);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd7; bus.cmd_data = 4'd15;
    @(posedge clk); #1;              // MUL cycle 1
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);       // MUL cycle 3
    #1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mulrst_busy_before got %b want 1", bus.busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mulrst_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.acc !== 4'd0) begin n_err++; $display("FAIL mulrst_acc got %0d want 0", bus.acc); end
    n_cmp++; if (bus.zero_flag !== 1'b1) begin n_err++; $display("FAIL mulrst_zero got %b want 1", bus.zero_flag); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mulrst_done got %b want 0", bus.done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({bus.cmd_ready, bus.done} !== 2'b10) begin n_err++; $display("FAIL mulrst_after ready/done got %b want 10", {bus.cmd_ready, bus.done}); end
    m_acc = 4'd0; m_ovr = 1'b0; m_zero = 1'b1;
  endtask

  // ADD 1 held valid across a MUL: only taken in the done cycle, applied once
  task automatic test_back_to_back();
    int bc; logic rdy, dn, dx;
    logic [3:0] a, d;
    int exp_bc;
    for (int t = 0; t < 4; t++) begin
      a = 4'($urandom);
      d = 4'($urandom_range(1, 15));
      run_cmd(3'd0, a, bc, rdy, dn, dx);
      model_apply(3'd0, a);
      bus.cmd_valid = 1'b1; bus.cmd_op = 3'd7; bus.cmd_data = d;
      @(posedge clk); #1;
      bus.cmd_op = 3'd3; bus.cmd_data = 4'd1;
      bc = 0;
      while (bus.busy && bc < 40) begin
        n_cmp++; if (bus.acc !== a) begin n_err++; $display("FAIL b2b%0d_hold acc got %0d want %0d", t, bus.acc, a); end
        bc++;
        @(posedge clk); #1;
      end
      model_apply(3'd7, d);
      exp_bc = int'(d) + 1;
      n_cmp++; if (bc !== exp_bc) begin n_err++; $display("FAIL b2b%0d_mulbusy got %0d want %0d", t, bc, exp_bc); end
      n_cmp++; if ({bus.done, bus.cmd_ready, bus.acc} !== {1'b1, 1'b1, m_acc}) begin
        n_err++; $display("FAIL b2b%0d_mul done/ready/acc got %b/%b/%0d want 1/1/%0d", t, bus.done, bus.cmd_ready, bus.acc, m_acc);
      end
      @(posedge clk); #1;            // ADD accepted here
      bus.cmd_valid = 1'b0;
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b%0d_accept busy got %b want 1", t, bus.busy); end
      @(posedge clk); #1;
      model_apply(3'd3, 4'd1);
      n_cmp++; if ({bus.done, bus.acc, bus.ovr_flag} !== {1'b1, m_acc, m_ovr}) begin
        n_err++; $display("FAIL b2b%0d_add done/acc/ovr got %b/%0d/%b want 1/%0d/%b", t, bus.done, bus.acc, bus.ovr_flag, m_acc, m_ovr);
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if ({bus.busy, bus.done, bus.acc} !== {1'b0, 1'b0, m_acc}) begin
        n_err++; $display("FAIL b2b%0d_once busy/done/acc got %b/%b/%0d want 0/0/%0d", t, bus.busy, bus.done, bus.acc, m_acc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mul_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
